// File: rtl/dioptase_pkg.sv
// Register file geometry shared by decode and the reg_file slice.
package dioptase_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int RET_REG  = 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: index mux, optional same-cycle write bypass, output flop.
// Bypass is built only when REGFILE_BYPASS_EN is defined; otherwise reads see pre-write contents.
module reg_file_rd_port
  import dioptase_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  reg_idx_t                         i_raddr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  i_regs,
  input  logic                             i_we0,
  input  reg_idx_t                         i_waddr0,
  input  logic [DATA_W-1:0]                i_wdata0,
  input  logic                             i_we1,
  input  reg_idx_t                         i_waddr1,
  input  logic [DATA_W-1:0]                i_wdata1,
  output logic [DATA_W-1:0]                o_rdata
);
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] r_rdata;

`ifdef REGFILE_BYPASS_EN
  // Port 0 checked last so it wins when both write ports hit the read index.
  always_comb begin
    w_rd = i_regs[i_raddr];
    if (i_we1 && (i_waddr1 == i_raddr)) w_rd = i_wdata1;
    if (i_we0 && (i_waddr0 == i_raddr)) w_rd = i_wdata0;
    if (i_raddr == '0) w_rd = '0;
  end
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{i_we0, i_waddr0, i_wdata0, i_we1, i_waddr1, i_wdata1};

  always_comb begin
    w_rd = i_regs[i_raddr];
    if (i_raddr == '0) w_rd = '0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= w_rd;
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file: two registered read ports, two write ports, r0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file
  import dioptase_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  reg_idx_t          raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  reg_idx_t          raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we0,
  input  reg_idx_t          waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  reg_idx_t          waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] ret_val
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  // Port 1 assigned first so port 0 overrides on an index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      if (we1 && (waddr1 != '0)) r_regs[waddr1] <= wdata1;
      if (we0 && (waddr0 != '0)) r_regs[waddr0] <= wdata0;
    end
  end

  assign ret_val = r_regs[RET_REG];

  reg_file_rd_port u_rd0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr  (raddr0),
    .i_regs   (r_regs),
    .i_we0    (we0),
    .i_waddr0 (waddr0),
    .i_wdata0 (wdata0),
    .i_we1    (we1),
    .i_waddr1 (waddr1),
    .i_wdata1 (wdata1),
    .o_rdata  (rdata0)
  );

  reg_file_rd_port u_rd1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr  (raddr1),
    .i_regs   (r_regs),
    .i_we0    (we0),
    .i_waddr0 (waddr0),
    .i_wdata0 (wdata0),
    .i_we1    (we1),
    .i_waddr1 (waddr1),
    .i_wdata1 (wdata1),
    .o_rdata  (rdata1)
  );
endmodule

// File: tb/tb_reg_file.sv
// Scoreboarded bench for reg_file: array reference model, directed cases, then random traffic.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr0, raddr1, waddr0, waddr1;
  logic [31:0] rdata0, rdata1, wdata0, wdata1, ret_val;
  logic        we0, we1;

  typedef struct {
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rv;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .rdata0(rdata0),
    .raddr1(raddr1), .rdata1(rdata1),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .ret_val(ret_val)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a read of index ra should return, given the writes issued in the same cycle.
  function automatic logic [31:0] model_rd(input logic [4:0] ra,
                                           input logic a_we0, input logic [4:0] a_wa0, input logic [31:0] a_wd0,
                                           input logic a_we1, input logic [4:0] a_wa1, input logic [31:0] a_wd1);
    if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (a_we0 && a_wa0 == ra) return a_wd0;
    if (a_we1 && a_wa1 == ra) return a_wd1;
`endif
    return mem[ra];
  endfunction

  task automatic cycle(input logic a_we0, input logic [4:0] a_wa0, input logic [31:0] a_wd0,
                       input logic a_we1, input logic [4:0] a_wa1, input logic [31:0] a_wd1,
                       input logic [4:0] a_ra0, input logic [4:0] a_ra1);
    exp_t e;
    @(negedge clk);
    we0 = a_we0; waddr0 = a_wa0; wdata0 = a_wd0;
    we1 = a_we1; waddr1 = a_wa1; wdata1 = a_wd1;
    raddr0 = a_ra0; raddr1 = a_ra1;
    e.rd0 = model_rd(a_ra0, a_we0, a_wa0, a_wd0, a_we1, a_wa1, a_wd1);
    e.rd1 = model_rd(a_ra1, a_we0, a_wa0, a_wd0, a_we1, a_wa1, a_wd1);
    if (a_we1 && a_wa1 != 5'd0) mem[a_wa1] = a_wd1;
    if (a_we0 && a_wa0 != 5'd0) mem[a_wa0] = a_wd0;
    e.rv = mem[1];
    sb.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  // Monitor: the DUT presents a fresh read result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_rdata0", rdata0, e.rd0);
        chk("sb_rdata1", rdata1, e.rd1);
        chk("sb_ret_val", ret_val, e.rv);
      end
    end
  end

  initial begin
    int wait_cnt;
    logic [4:0] ra, wa;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; raddr0 = 0; raddr1 = 0;
    #12;
    chk("reset_rdata0", rdata0, 32'h0);
    chk("reset_rdata1", rdata1, 32'h0);
    chk("reset_ret_val", ret_val, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), $urandom | 32'h1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    @(posedge clk);
    #3;
    // Async reset mid-cycle with a write pending.
    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'hBAD0BAD0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdata0", rdata0, 32'h0);
    chk("async_rst_rdata1", rdata1, 32'h0);
    chk("async_rst_ret_val", ret_val, 32'h0);
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    we0 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i += 2) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1));

    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(posedge clk); #2;
    chk("r5_rdata0", rdata0, 32'hDEADBEEF);
    chk("r5_rdata1", rdata1, 32'hDEADBEEF);

    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge clk); #2;
    chk("r0_zero", rdata0, 32'h0);

    cycle(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'h0000_5555, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    @(posedge clk); #2;
    chk("r7_port0_wins", rdata0, 32'hAAAA_0000);
    cycle(1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd8, 32'h0000_5555, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
    @(posedge clk); #2;
    chk("r7_dual", rdata0, 32'hAAAA_0000);
    chk("r8_dual", rdata1, 32'h0000_5555);

    cycle(1'b1, 5'd1, 32'h42, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge clk); #2;
    chk("ret_val_r1", ret_val, 32'h42);

    cycle(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    @(posedge clk); #2;
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_cycle", rdata0, 32'h77);
`else
    chk("rw_same_cycle", rdata0, 32'h11);
`endif

    for (int n = 0; n < 400; n++) begin
      ra = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      cycle(1'($urandom), wa, $urandom,
            1'($urandom), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)), $urandom,
            ra, ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
    end
    idle();

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
